// File: rtl/instr_mem_loadable_if.sv
// instr_mem_loadable_if - programming, fetch and status signals of the loadable instruction memory
//
// Purpose: groups every non-clock signal of instr_mem_loadable into one bundle.
// Modports:
//   master : control unit / loader side (drives prog_*, start and the fetch request)
//   slave  : memory side (drives instr, the fetch flags and the load status)
// Signals:
//   prog_en, prog_we, prog_data  load-mode level, write strobe, word to append
//   start                        IDLE -> RUN without loading
//   rd_req, rd_addr, stall       fetch request, word address, output hold
//   instr, instr_valid, is_halt  registered fetch response and its flags
//   addr_fault                   response came from an address >= DEPTH
//   wr_count, prog_ovf           words loaded since entering LOAD, sticky overflow
//   running                      memory is in RUN
interface instr_mem_loadable_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              prog_en;
    logic              prog_we;
    logic [DATA_W-1:0] prog_data;
    logic              start;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              is_halt;
    logic              addr_fault;
    logic [ADDR_W:0]   wr_count;
    logic              prog_ovf;
    logic              running;

    modport master (
        output prog_en, prog_we, prog_data, start, rd_req, rd_addr, stall,
        input  instr, instr_valid, is_halt, addr_fault, wr_count, prog_ovf, running
    );

    modport slave (
        input  prog_en, prog_we, prog_data, start, rd_req, rd_addr, stall,
        output instr, instr_valid, is_halt, addr_fault, wr_count, prog_ovf, running
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable - run-time loadable instruction memory with registered fetch port
//
// Purpose: DEPTH x DATA_W program store. In LOAD, words are appended at wr_count
// from the programming stream; in RUN, fetches return mem[rd_addr] one cycle later
// with valid, HALT and out-of-range flags. All outputs are registered.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-high reset (memory contents are preserved)
//   bus  slave modport of instr_mem_loadable_if (see interface header)
module instr_mem_loadable #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 6,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_mem_loadable_if.slave  bus
);

    // Narrowest index that covers the implemented words; keeps array selects exact.
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] instr_q,    instr_d;
    logic              valid_q,    valid_d;
    logic              halt_q,     halt_d;
    logic              fault_q,    fault_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic              ovf_q,      ovf_d;
    logic              running_q,  running_d;

    logic              mem_we;
    logic              load_full;
    logic              in_range;
    logic [DATA_W-1:0] mem_rd;

    assign load_full = (wr_count_q >= DEPTH_C);
    assign in_range  = ({1'b0, bus.rd_addr} < DEPTH_C);
    // Only consumed when in_range, so the truncated index is always a real word.
    assign mem_rd    = mem[bus.rd_addr[IDX_W-1:0]];

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // prog_en wins over start.
                if (bus.prog_en) begin
                    state_d = ST_LOAD;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (!bus.prog_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.prog_en) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- load and fetch datapath ----------------
    always_comb begin
        wr_count_d = wr_count_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        instr_d    = instr_q;
        valid_d    = valid_q;
        halt_d     = halt_q;
        fault_d    = fault_q;
        running_d  = (state_d == ST_RUN);

        // Entering LOAD restarts the append pointer and the overflow flag.
        if (state_q != ST_LOAD && state_d == ST_LOAD) begin
            wr_count_d = '0;
            ovf_d      = 1'b0;
        end

        // Writes follow the current state, so a strobe on the cycle prog_en
        // falls still lands.
        if (state_q == ST_LOAD && bus.prog_we) begin
            if (!load_full) begin
                mem_we     = 1'b1;
                wr_count_d = wr_count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (state_q == ST_RUN && !bus.prog_en) begin
            if (!bus.stall) begin
                if (bus.rd_req) begin
                    valid_d = 1'b1;
                    if (in_range) begin
                        instr_d = mem_rd;
                        fault_d = 1'b0;
                        halt_d  = (mem_rd == HALT_WORD);
                    end else begin
                        instr_d = NOP_WORD;
                        fault_d = 1'b1;
                        halt_d  = (NOP_WORD == HALT_WORD);
                    end
                end else begin
                    // instr keeps its last value; only the flags drop.
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    halt_d  = 1'b0;
                end
            end
        end else begin
            // Outside RUN, and on the RUN->LOAD edge, no response is presented.
            valid_d = 1'b0;
            halt_d  = 1'b0;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            fault_q    <= 1'b0;
            wr_count_q <= '0;
            ovf_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            halt_q     <= halt_d;
            fault_q    <= fault_d;
            wr_count_q <= wr_count_d;
            ovf_q      <= ovf_d;
            running_q  <= running_d;
        end
    end

    // Array has no reset: the program survives rst, including a reset mid-LOAD.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_count_q[IDX_W-1:0]] <= bus.prog_data;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.is_halt     = halt_q;
    assign bus.addr_fault  = fault_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.prog_ovf    = ovf_q;
    assign bus.running     = running_q;

endmodule
